// File: rtl/axi3_line_fetch.sv
// axi3_line_fetch_pkg: AXI3 read-channel bundles shared by the fetch master and its bench.
//   axi3_rd_req_t  : master-driven AR fields plus rready
//   axi3_rd_resp_t : slave-driven arready plus R fields
//
// axi3_line_fetch: cache-line refill master. It accepts one line-aligned
// request, issues a single INCR burst of LINE_WORDS 32-bit beats, collects the
// beats into a line buffer and returns the whole line with an error flag.
// Only one burst is outstanding at a time.
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : refill request; req_addr offset bits are ignored
//   req_ready     : high only while idle
//   line_valid    : one-cycle pulse, line_data/line_err valid
//   line_data     : word i at bits [32*i+31:32*i]
//   line_err      : some beat had rresp != OKAY, or rlast was misplaced
//   axi3_rd_req   : AR/R master signals
//   arid          : constant ARID
//   axi3_rd_resp  : AR/R slave signals
//   rid           : unused, single outstanding burst
package axi3_line_fetch_pkg;
  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        rready;
  } axi3_rd_req_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
  } axi3_rd_resp_t;
endpackage

module axi3_line_fetch
  import axi3_line_fetch_pkg::*;
#(
  parameter int unsigned          LINE_WORDS = 8,
  parameter int unsigned          BUS_WIDTH  = 4,
  parameter logic [BUS_WIDTH-1:0] ARID       = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  output logic                     req_ready,
  output logic                     line_valid,
  output logic [32*LINE_WORDS-1:0] line_data,
  output logic                     line_err,
  output axi3_rd_req_t             axi3_rd_req,
  output logic [BUS_WIDTH-1:0]     arid,
  input  axi3_rd_resp_t            axi3_rd_resp,
  input  logic [BUS_WIDTH-1:0]     rid
);

  localparam int unsigned     CW        = $clog2(LINE_WORDS);
  localparam logic [CW-1:0]   LAST      = CW'(LINE_WORDS - 1);
  localparam logic [31:0]     ADDR_MASK = ~32'(LINE_WORDS * 4 - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           err;
  logic           arvalid;
  logic           rready;
  logic [31:0]    araddr;
  logic           beat_err;
  logic           unused_rid;

  assign unused_rid = ^rid;

  // A beat is bad on a non-OKAY response or when rlast disagrees with the counter.
  assign beat_err = (axi3_rd_resp.rresp != 2'b00) ||
                    (axi3_rd_resp.rlast != (cnt == LAST));

  // Handshake outputs are registered with the state so they never depend on the slave.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      line_valid <= 1'b0;
      line_err   <= 1'b0;
      line_data  <= '0;
      araddr     <= '0;
      cnt        <= '0;
      err        <= 1'b0;
    end else begin
      line_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            araddr    <= req_addr & ADDR_MASK;
            cnt       <= '0;
            err       <= 1'b0;
            req_ready <= 1'b0;
            arvalid   <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (axi3_rd_resp.arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (axi3_rd_resp.rvalid) begin
            line_data[{cnt, 5'd0} +: 32] <= axi3_rd_resp.rdata;
            cnt <= cnt + CW'(1);
            err <= err | beat_err;
            // Completion is counted, not taken from rlast.
            if (cnt == LAST) begin
              rready     <= 1'b0;
              line_valid <= 1'b1;
              line_err   <= err | beat_err;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    axi3_rd_req         = '0;
    axi3_rd_req.arvalid = arvalid;
    axi3_rd_req.araddr  = araddr;
    axi3_rd_req.arlen   = 4'(LINE_WORDS - 1);
    axi3_rd_req.arsize  = 3'b010;
    axi3_rd_req.arburst = 2'b01;
    axi3_rd_req.arlock  = '0;
    axi3_rd_req.arcache = '0;
    axi3_rd_req.arprot  = '0;
    axi3_rd_req.rready  = rready;
  end

  assign arid = ARID;

endmodule

// File: tb/tb_axi3_line_fetch.sv
// Directed bench for axi3_line_fetch (LINE_WORDS=8): reset values, zero-wait
// burst, AR backpressure, gapped R beats, error flagging, reset mid-burst and
// back-to-back requests with req_valid held high.
module tb_axi3_line_fetch;
  import axi3_line_fetch_pkg::*;

  localparam int unsigned LW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic [31:0]     req_addr;
  logic            req_ready;
  logic            line_valid;
  logic [32*LW-1:0] line_data;
  logic            line_err;
  axi3_rd_req_t    rd_req;
  logic [3:0]      arid;
  axi3_rd_resp_t   rd_resp;
  logic [3:0]      rid;

  logic            arready, rvalid, rlast;
  logic [31:0]     rdata;
  logic [1:0]      rresp;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned ar_hs    = 0;
  int unsigned lv_cnt   = 0;
  int unsigned ar0, lv0;

  always #5 clk = ~clk;

  always_comb begin
    rd_resp         = '0;
    rd_resp.arready = arready;
    rd_resp.rvalid  = rvalid;
    rd_resp.rdata   = rdata;
    rd_resp.rresp   = rresp;
    rd_resp.rlast   = rlast;
  end

  always @(posedge clk) begin
    if (rd_req.arvalid && arready) ar_hs <= ar_hs + 1;
    if (line_valid) lv_cnt <= lv_cnt + 1;
  end

  axi3_line_fetch #(.LINE_WORDS(LW), .BUS_WIDTH(4), .ARID(4'h5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .line_valid  (line_valid),
    .line_data   (line_data),
    .line_err    (line_err),
    .axi3_rd_req (rd_req),
    .arid        (arid),
    .axi3_rd_resp(rd_resp),
    .rid         (rid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dat(input logic [15:0] seed, input int unsigned i);
    return {seed, 16'(i * 32'h1111)};
  endfunction

  task automatic chk_line(input string tag, input logic [15:0] seed);
    for (int i = 0; i < LW; i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(line_data[32*i +: 32]), 64'(dat(seed, i)));
  endtask

  // Presents one request for one cycle; returns in the ADDR cycle.
  task automatic request(input logic [31:0] a, input logic [31:0] exp_araddr, input string tag);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
    chk({tag, "_arvalid"}, 64'(rd_req.arvalid), 64'd1);
    chk({tag, "_araddr"}, 64'(rd_req.araddr), 64'(exp_araddr));
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] rr, input logic last);
    rvalid = 1'b1; rdata = d; rresp = rr; rlast = last;
    tick();
    rvalid = 1'b0; rresp = 2'b00; rlast = 1'b0;
  endtask

  // Full 8-beat burst from the DATA state; ends in the DONE cycle.
  task automatic burst(input logic [15:0] seed, input int unsigned err_beat,
                       input int unsigned last_at, input logic gap, input string tag);
    for (int unsigned i = 0; i < LW; i++) begin
      beat(dat(seed, i), (i == err_beat) ? 2'b10 : 2'b00, i == last_at);
      if (i < LW - 1) begin
        chk($sformatf("%s_lv_b%0d", tag, i), 64'(line_valid), 64'd0);
        if (gap) begin
          tick();
          chk($sformatf("%s_lv_gap%0d", tag, i), 64'(line_valid), 64'd0);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rid = 4'h3;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00;
    tick(); tick();

    // Reset state and constant AR fields
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_arvalid", 64'(rd_req.arvalid), 64'd0);
    chk("rst_rready", 64'(rd_req.rready), 64'd0);
    chk("rst_line_valid", 64'(line_valid), 64'd0);
    chk("rst_line_err", 64'(line_err), 64'd0);
    chk("rst_line_data", 64'(line_data == '0), 64'd1);
    chk("rst_araddr", 64'(rd_req.araddr), 64'd0);
    chk("arlen", 64'(rd_req.arlen), 64'd7);
    chk("arsize", 64'(rd_req.arsize), 64'd2);
    chk("arburst", 64'(rd_req.arburst), 64'd1);
    chk("arlock_cache_prot", 64'({rd_req.arlock, rd_req.arcache, rd_req.arprot}), 64'd0);
    chk("arid", 64'(arid), 64'h5);
    rst = 1'b0;
    tick();

    // 1: zero-wait slave
    arready = 1'b1;
    ar0 = ar_hs;
    request(32'h1FC0_0014, 32'h1FC0_0000, "t1");
    chk("t1_rready_addr", 64'(rd_req.rready), 64'd0);
    tick();
    chk("t1_arvalid_drop", 64'(rd_req.arvalid), 64'd0);
    chk("t1_rready", 64'(rd_req.rready), 64'd1);
    chk("t1_ar_hs", 64'(ar_hs - ar0), 64'd1);
    burst(16'h1111, 99, 7, 1'b0, "t1");
    chk("t1_line_valid", 64'(line_valid), 64'd1);
    chk("t1_line_err", 64'(line_err), 64'd0);
    chk("t1_rready_done", 64'(rd_req.rready), 64'd0);
    chk_line("t1", 16'h1111);
    tick();
    chk("t1_lv_pulse", 64'(line_valid), 64'd0);
    chk("t1_idle_ready", 64'(req_ready), 64'd1);
    chk_line("t1_hold", 16'h1111);

    // 2: arready low for 5 cycles
    arready = 1'b0;
    ar0 = ar_hs;
    request(32'h0000_1234, 32'h0000_1220, "t2");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_arvalid_c%0d", k), 64'(rd_req.arvalid), 64'd1);
      chk($sformatf("t2_araddr_c%0d", k), 64'(rd_req.araddr), 64'h1220);
      if (k < 4) tick();
    end
    arready = 1'b1;
    tick();
    chk("t2_ar_hs", 64'(ar_hs - ar0), 64'd1);
    chk("t2_arvalid_drop", 64'(rd_req.arvalid), 64'd0);
    chk("t2_rready", 64'(rd_req.rready), 64'd1);
    burst(16'h2222, 99, 7, 1'b0, "t2");
    chk("t2_line_valid", 64'(line_valid), 64'd1);
    chk_line("t2", 16'h2222);
    tick();

    // 3: rvalid during ADDR is not taken; then toggling rvalid
    arready = 1'b0;
    lv0 = lv_cnt;
    request(32'h8000_0040, 32'h8000_0040, "t3");
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    chk("t3_rready_addr", 64'(rd_req.rready), 64'd0);
    rvalid = 1'b0; arready = 1'b1;
    tick();
    chk("t3_rready", 64'(rd_req.rready), 64'd1);
    burst(16'h3333, 99, 7, 1'b1, "t3");
    chk("t3_line_valid", 64'(line_valid), 64'd1);
    chk_line("t3", 16'h3333);
    tick();
    chk("t3_lv_once", 64'(lv_cnt - lv0), 64'd1);
    chk("t3_lv_low", 64'(line_valid), 64'd0);

    // 4a: SLVERR on beat 3
    request(32'h0000_0100, 32'h0000_0100, "t4a");
    tick();
    burst(16'h4444, 3, 7, 1'b0, "t4a");
    chk("t4a_line_valid", 64'(line_valid), 64'd1);
    chk("t4a_line_err", 64'(line_err), 64'd1);
    chk_line("t4a", 16'h4444);
    tick();
    chk("t4a_err_stable", 64'(line_err), 64'd1);

    // 4b: rlast early on beat 5, completion still after beat 7
    request(32'h0000_0200, 32'h0000_0200, "t4b");
    tick();
    burst(16'h5555, 99, 5, 1'b0, "t4b");
    chk("t4b_line_valid", 64'(line_valid), 64'd1);
    chk("t4b_line_err", 64'(line_err), 64'd1);
    tick();

    // 5: reset after beat 4, then a clean request
    request(32'h0000_0300, 32'h0000_0300, "t5");
    tick();
    for (int unsigned i = 0; i < 5; i++) beat(dat(16'h6666, i), 2'b00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_req_ready", 64'(req_ready), 64'd1);
    chk("t5_arvalid", 64'(rd_req.arvalid), 64'd0);
    chk("t5_rready", 64'(rd_req.rready), 64'd0);
    chk("t5_line_valid", 64'(line_valid), 64'd0);
    chk("t5_line_err", 64'(line_err), 64'd0);
    chk("t5_line_data", 64'(line_data == '0), 64'd1);
    chk("t5_araddr", 64'(rd_req.araddr), 64'd0);
    request(32'h0000_0337, 32'h0000_0320, "t5b");
    tick();
    burst(16'h7777, 99, 7, 1'b0, "t5b");
    chk("t5b_line_valid", 64'(line_valid), 64'd1);
    chk("t5b_line_err", 64'(line_err), 64'd0);
    chk_line("t5b", 16'h7777);
    tick();

    // 6: req_valid held across two back-to-back lines
    ar0 = ar_hs;
    req_valid = 1'b1;
    req_addr  = 32'h0000_0404;
    tick();
    chk("t6_arvalid", 64'(rd_req.arvalid), 64'd1);
    chk("t6_araddr", 64'(rd_req.araddr), 64'h400);
    tick();
    burst(16'h8888, 99, 7, 1'b0, "t6");
    chk("t6_line_valid", 64'(line_valid), 64'd1);
    chk("t6_ready_done", 64'(req_ready), 64'd0);
    chk("t6_ar_hs_one", 64'(ar_hs - ar0), 64'd1);
    req_addr = 32'h0000_0488;
    tick();
    chk("t6_idle_ready", 64'(req_ready), 64'd1);
    chk("t6_idle_arvalid", 64'(rd_req.arvalid), 64'd0);
    chk("t6_idle_araddr", 64'(rd_req.araddr), 64'h400);
    chk_line("t6_hold", 16'h8888);
    tick();
    req_valid = 1'b0;
    chk("t6_second_arvalid", 64'(rd_req.arvalid), 64'd1);
    chk("t6_second_araddr", 64'(rd_req.araddr), 64'h480);
    chk("t6_second_ready", 64'(req_ready), 64'd0);
    chk_line("t6_hold2", 16'h8888);
    tick();
    burst(16'h9999, 99, 7, 1'b0, "t6b");
    chk("t6b_line_valid", 64'(line_valid), 64'd1);
    chk("t6b_line_err", 64'(line_err), 64'd0);
    chk("t6_ar_hs_two", 64'(ar_hs - ar0), 64'd2);
    chk_line("t6b", 16'h9999);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
